// File: rtl/core_pkg.sv
// Shared constants and types for the writeback / register-file slice.
// The wb_sel encoding matches the mem_to_reg pipeline bit directly.
package core_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 64;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;
endpackage

// File: rtl/regfile_array.sv
// Raw register storage: synchronous clear, one write port, two combinational
// read ports. No x0 handling here; the top masks address zero.
module regfile_array
  import core_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int NR = NUM_REGS,
  parameter int AW = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem_r [NR];

  // Storage update: full clear on reset, otherwise single-port write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_r[raddr1];
  assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result, commits it to the register file, offers
// bypassed decode reads and an EX forward tap, and counts retired instructions.
module writeback_regfile
  import core_pkg::*;
#(
  parameter int XW = XLEN,
  parameter int CW = CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XW-1:0]         in_alu_out,
  input  logic [XW-1:0]         in_mem_out,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_mem_to_reg,
  input  logic                  in_write_enable,
  input  logic                  in_retire,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XW-1:0]         rs1_data,
  output logic [XW-1:0]         rs2_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XW-1:0]         fwd_data,
  output logic [CW-1:0]         instret
);

  wb_sel_e       wb_sel_s;
  logic [XW-1:0] wb_data_s;
  logic          wb_en_s;
  logic [XW-1:0] raw1_s;
  logic [XW-1:0] raw2_s;
  logic [CW-1:0] instret_r;

  assign wb_sel_s = wb_sel_e'(in_mem_to_reg);
  assign wb_en_s  = in_write_enable && (in_rd != ZERO_REG);

  // Writeback result select
  always_comb begin
    wb_data_s = in_alu_out;
    case (wb_sel_s)
      WB_ALU:  wb_data_s = in_alu_out;
      WB_MEM:  wb_data_s = in_mem_out;
      default: wb_data_s = in_alu_out;
    endcase
  end

  regfile_array #(
    .DW(XW),
    .NR(NUM_REGS),
    .AW(REG_ADDR_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en_s),
    .waddr  (in_rd),
    .wdata  (wb_data_s),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (raw1_s),
    .rdata2 (raw2_s)
  );

  // Read port 1: x0 is hard zero, otherwise write-through bypass over the array
  always_comb begin
    rs1_data = raw1_s;
    if (rs1_addr == ZERO_REG) begin
      rs1_data = '0;
    end else if (wb_en_s && (rs1_addr == in_rd)) begin
      rs1_data = wb_data_s;
    end else begin
      rs1_data = raw1_s;
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rs2_data = raw2_s;
    if (rs2_addr == ZERO_REG) begin
      rs2_data = '0;
    end else if (wb_en_s && (rs2_addr == in_rd)) begin
      rs2_data = wb_data_s;
    end else begin
      rs2_data = raw2_s;
    end
  end

  assign fwd_valid = wb_en_s;
  assign fwd_rd    = in_rd;
  assign fwd_data  = wb_data_s;

  // Retired-instruction counter; retires without a write (stores, branches) count too
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= '0;
    end else if (in_retire) begin
      instret_r <= instret_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign instret = instret_r;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench: stimulus pushes expected outputs from an array-based
// reference model; a negedge monitor pops and compares.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_alu_out, in_mem_out;
  logic [4:0]  in_rd, rs1_addr, rs2_addr;
  logic        in_mem_to_reg, in_write_enable, in_retire;
  logic [31:0] rs1_data, rs2_data, fwd_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] instret;
  // small-counter instance used to observe wrap-around
  logic [31:0] s_rs1, s_rs2, s_fd;
  logic        s_fv;
  logic [4:0]  s_frd;
  logic [3:0]  instret_s;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .reset(reset), .in_alu_out(in_alu_out), .in_mem_out(in_mem_out),
    .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
    .in_retire(in_retire), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  writeback_regfile #(.CW(4)) dut_small (
    .clk(clk), .reset(reset), .in_alu_out(in_alu_out), .in_mem_out(in_mem_out),
    .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
    .in_retire(in_retire), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(s_rs1), .rs2_data(s_rs2), .fwd_valid(s_fv),
    .fwd_rd(s_frd), .fwd_data(s_fd), .instret(instret_s)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fd;
    logic [63:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // reference model: architectural state only
  logic [31:0]     m_regs [32];
  longint unsigned m_cnt;
  logic [3:0]      m_cnt_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rs1_data", 64'(rs1_data), 64'(e.rs1));
      chk("rs2_data", 64'(rs2_data), 64'(e.rs2));
      chk("fwd_valid", 64'(fwd_valid), 64'(e.fv));
      if (e.fv) begin
        chk("fwd_rd", 64'(fwd_rd), 64'(e.frd));
        chk("fwd_data", 64'(fwd_data), 64'(e.fd));
      end
      chk("instret", instret, e.cnt);
      chk("instret_wrap", 64'(instret_s), 64'(e.cnt_s));
    end
  end

  task automatic cycle(input logic rst, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd, input logic m2r, input logic we,
                       input logic ret, input logic [4:0] a1, input logic [4:0] a2,
                       input bit push);
    exp_t e;
    logic [31:0] wb;
    logic en;
    @(posedge clk);
    #1;
    reset = rst; in_alu_out = alu; in_mem_out = mem; in_rd = rd;
    in_mem_to_reg = m2r; in_write_enable = we; in_retire = ret;
    rs1_addr = a1; rs2_addr = a2;
    wb = m2r ? mem : alu;
    en = we && (rd != 5'd0);
    e.rs1 = (a1 == 5'd0) ? 32'd0 : ((en && a1 == rd) ? wb : m_regs[a1]);
    e.rs2 = (a2 == 5'd0) ? 32'd0 : ((en && a2 == rd) ? wb : m_regs[a2]);
    e.fv = en; e.frd = rd; e.fd = wb;
    e.cnt = m_cnt; e.cnt_s = m_cnt_s;
    if (push) exp_q.push_back(e);
    // state the coming edge will produce
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_cnt = 64'd0; m_cnt_s = 4'd0;
    end else begin
      if (en) m_regs[rd] = wb;
      if (ret) begin
        m_cnt = m_cnt + 64'd1;
        m_cnt_s = m_cnt_s + 4'd1;
      end
    end
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_cnt = 64'd0; m_cnt_s = 4'd0;
    reset = 1'b1; in_alu_out = 32'd0; in_mem_out = 32'd0; in_rd = 5'd0;
    in_mem_to_reg = 1'b0; in_write_enable = 1'b0; in_retire = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    cycle(1'b1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    // all registers read zero after reset
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'(i), 5'(31 - i), 1'b1);
    // ALU and memory writeback paths
    cycle(1'b0, 32'hDEADBEEF, 32'h12345678, 5'd5, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 32'hDEADBEEF, 32'h12345678, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd6, 5'd5, 1'b1);
    // dual-port same-cycle bypass
    cycle(1'b0, 32'hA5A5A5A5, 32'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 1'b1);
    // x0 is never written and never bypassed
    cycle(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1);
    // retire without writing, long enough to wrap the 4-bit counter
    for (int i = 0; i < 18; i++)
      cycle(1'b0, 32'h11111111, 32'h22222222, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 5'd6, 1'b1);
    // reset in the middle of a commit
    cycle(1'b0, 32'h55, 32'd0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1);
    cycle(1'b1, 32'h99, 32'd0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 1'b1);
    cycle(1'b0, 32'h99, 32'd0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd4, 5'd0, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd7, 1'b1);
    // randomized traffic with addresses biased towards the write target
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd, a1, a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 49) == 0), $urandom, $urandom, rd,
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), a1, a2, 1'b1);
    end
    cycle(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0);
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      tests++;
      if (exp_q.size() > 0) begin
        fails++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Final pipeline stage: consumes MEM/WB pipeline register outputs (ALU result, memory data, rd, mem_to_reg, write_enable) and commits the selected result into a 32x32 integer register file.
- Provides two read ports to decode with write-through bypass, plus a forward tap for the EX-stage forwarding unit.
- Counts retired instructions.

Parameters:
- XLEN, 32, data width of registers and writeback values.
- NUM_REGS, 32, number of architectural registers (x0..x31).
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_alu_out  in  XLEN  ALU result from MEM/WB.
- in_mem_out  in  XLEN  load data from MEM/WB.
- in_rd  in  5  destination register index.
- in_mem_to_reg  in  1  1 selects in_mem_out, 0 selects in_alu_out.
- in_write_enable  in  1  commit request for rd.
- in_retire  in  1  valid instruction leaving MEM/WB this cycle (bubble = 0).
- rs1_addr  in  5  decode read port 1 address.
- rs2_addr  in  5  decode read port 2 address.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- fwd_valid  out  1  writeback value is architecturally written this cycle.
- fwd_rd  out  5  register being written this cycle.
- fwd_data  out  XLEN  value being written this cycle.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Writeback select (combinational): wb_data = in_mem_to_reg ? in_mem_out : in_alu_out.
- Commit: wb_en = in_write_enable && (in_rd != 0).
  - On the clk posedge with wb_en=1 and reset=0, regs[in_rd] <= wb_data.
  - Write latency: 1 edge.
- x0: never written; reads of address 0 always return 0 and are never bypassed.
- Read ports: combinational from the array, with write-through bypass.
  - If wb_en && rsN_addr == in_rd && rsN_addr != 0, rsN_data = wb_data (same-cycle value).
  - Otherwise rsN_data = regs[rsN_addr].
  - Both ports may bypass simultaneously when rs1_addr == rs2_addr == in_rd.
- Forward tap: fwd_valid = wb_en, fwd_rd = in_rd, fwd_data = wb_data; all combinational. fwd_rd and fwd_data are don't-care when fwd_valid = 0 (drive anyway, no X).
- instret: increments by 1 on each posedge with in_retire=1. It is independent of write_enable, because stores and branches retire without writing. It wraps modulo 2^CNT_W.
- Reset (synchronous, mid-operation included):
  - On a posedge with reset=1, all regs clear to 0 and instret clears to 0.
  - Any concurrent commit or retire is discarded.
  - While reset is held, rsN_data still reads the array (zeros), and bypass still reflects wb_en (combinational).
  - The first commit takes effect on the first posedge with reset=0.
- No X propagation: the array is reset-cleared, with no initial-block reliance.

Decomposition:
- Shared package (core_pkg): XLEN, REG_ADDR_W=5, NUM_REGS, ZERO_REG=5'd0, CNT_W; wb_sel enum (WB_ALU=0, WB_MEM=1) matching the mem_to_reg encoding.
- One sub-module, regfile_array: the 32xXLEN storage with synchronous reset, one write port and two raw combinational read ports.
- The top owns the writeback mux, x0 masking, bypass, forward tap and instret counter.

Test Plan:
- Reset, then read x0..x31 on both ports -> all 0; instret = 0.
- alu_out=0xDEADBEEF, mem_out=0x12345678, rd=5, mem_to_reg=0, we=1, retire=1 for one edge -> next cycle rs1_addr=5 gives 0xDEADBEEF; instret = 1. Repeat with mem_to_reg=1, rd=6 -> x6 = 0x12345678.
- Same-cycle bypass: commit rd=7, alu_out=0xA5A5A5A5 with rs1_addr=rs2_addr=7 -> both rs1_data and rs2_data = 0xA5A5A5A5 before the edge; fwd_valid=1, fwd_rd=7.
- x0 protection: we=1, rd=0, alu_out=0xFFFFFFFF, rs1_addr=0 -> rs1_data=0 before and after the edge; fwd_valid=0.
- Retire without write: in_retire=1, we=0 for 3 cycles -> instret +3, registers unchanged. Preload instret near 2^CNT_W-1 (force/small-CNT_W build), retire once -> instret wraps to 0.
- Reset mid-operation: write x3=0x55, then assert reset with we=1, rd=3, alu_out=0x99 -> after the edge, x3=0 and instret=0; deassert and commit again -> x3=0x99.
